// File: rtl/tile_load_sequencer.sv
// tile_load_sequencer
// Fetches one convolution tile per iteration (IFM_WORDS IFM words, WGT_WORDS
// WGT words, BIAS_WORDS BIAS words) from shared memory through an arbiter
// port. It steers each returned word into the matching buffer, then presents
// the tile to the PE array with a ready/ack handshake. This repeats for
// num_tiles tiles.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   start, num_tiles,        run launch; count and bases captured in IDLE
//   ifm_base/wgt_base/bias_base
//   mem_req, mem_addr,       read request port; accepted when mem_req && mem_gnt,
//   mem_gnt, mem_rdata       data returns RD_LAT cycles after acceptance
//   buf_wr_en, buf_sel,      buffer write port (sel 01 IFM, 10 WGT, 11 BIAS)
//   buf_data
//   tile_ready, pe_ack       tile handshake with the PE array
//   tile_idx                 index of the tile being loaded/presented
//   busy, done               status; done pulses once at end of run
module tile_load_sequencer #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 2,
   parameter int IFM_WORDS  = 3,
   parameter int WGT_WORDS  = 3,
   parameter int BIAS_WORDS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [15:0]       num_tiles,
   input  logic [ADDR_W-1:0] ifm_base,
   input  logic [ADDR_W-1:0] wgt_base,
   input  logic [ADDR_W-1:0] bias_base,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              buf_wr_en,
   output logic [1:0]        buf_sel,
   output logic [DATA_W-1:0] buf_data,
   output logic              tile_ready,
   input  logic              pe_ack,
   output logic [15:0]       tile_idx,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_IFM  = 2'b01;
   localparam logic [1:0] SEL_WGT  = 2'b10;
   localparam logic [1:0] SEL_BIAS = 2'b11;

   localparam logic [7:0] IFM_LAST  = 8'(IFM_WORDS - 1);
   localparam logic [7:0] WGT_LAST  = 8'(WGT_WORDS - 1);
   localparam logic [7:0] BIAS_LAST = 8'(BIAS_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH_IFM,
      FETCH_WGT,
      FETCH_BIAS,
      DRAIN,
      READY,
      FIN
   } state_t;

   state_t state, state_nxt;

   logic [15:0]       num_tiles_q;
   logic [15:0]       tile_idx_q;
   logic [ADDR_W-1:0] ifm_ptr, wgt_ptr, bias_ptr;
   logic [7:0]        wcnt;        // words accepted in the current phase
   logic [1:0]        cur_sel;     // buffer code of the phase now requesting
   logic              phase_last;  // current request is the last of its phase
   logic              acc;         // request accepted this cycle
   logic              last_tile;

   // Tag pipeline: stage 1 is loaded at acceptance, stage RD_LAT lines up
   // with the returning mem_rdata.
   logic [RD_LAT:1]      vld_pipe;
   logic [RD_LAT:1][1:0] tag_pipe;

   assign last_tile = (tile_idx_q == num_tiles_q - 16'd1);
   assign acc       = mem_req & mem_gnt;

   always_comb begin
      state_nxt  = state;
      mem_req    = 1'b0;
      cur_sel    = SEL_NONE;
      phase_last = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (num_tiles == 16'd0) ? FIN : FETCH_IFM;
         end
         FETCH_IFM: begin
            mem_req    = 1'b1;
            cur_sel    = SEL_IFM;
            phase_last = (wcnt == IFM_LAST);
            if (mem_gnt && phase_last) state_nxt = FETCH_WGT;
         end
         FETCH_WGT: begin
            mem_req    = 1'b1;
            cur_sel    = SEL_WGT;
            phase_last = (wcnt == WGT_LAST);
            if (mem_gnt && phase_last) state_nxt = FETCH_BIAS;
         end
         FETCH_BIAS: begin
            mem_req    = 1'b1;
            cur_sel    = SEL_BIAS;
            phase_last = (wcnt == BIAS_LAST);
            if (mem_gnt && phase_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            // Empty pipe means the final write is on the buffer port this
            // cycle, so READY starts right after it.
            if (vld_pipe == '0) state_nxt = READY;
         end
         READY: begin
            if (pe_ack) state_nxt = last_tile ? FIN : FETCH_IFM;
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_addr = '0;
      case (cur_sel)
         SEL_IFM:  mem_addr = ifm_ptr;
         SEL_WGT:  mem_addr = wgt_ptr;
         SEL_BIAS: mem_addr = bias_ptr;
         default:  mem_addr = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         num_tiles_q <= '0;
         tile_idx_q  <= '0;
         ifm_ptr     <= '0;
         wgt_ptr     <= '0;
         bias_ptr    <= '0;
         wcnt        <= '0;
         vld_pipe    <= '0;
         tag_pipe    <= '0;
         buf_wr_en   <= 1'b0;
         buf_sel     <= SEL_NONE;
         buf_data    <= '0;
      end else begin
         state <= state_nxt;

         if (state == IDLE && start) begin
            num_tiles_q <= num_tiles;
            tile_idx_q  <= '0;
            ifm_ptr     <= ifm_base;
            wgt_ptr     <= wgt_base;
            bias_ptr    <= bias_base;
            wcnt        <= '0;
         end

         // Pointers are never rewound between tiles, so tile k naturally
         // starts where tile k-1 stopped.
         if (acc) begin
            wcnt <= phase_last ? 8'd0 : wcnt + 8'd1;
            case (cur_sel)
               SEL_IFM:  ifm_ptr  <= ifm_ptr  + ADDR_W'(1);
               SEL_WGT:  wgt_ptr  <= wgt_ptr  + ADDR_W'(1);
               SEL_BIAS: bias_ptr <= bias_ptr + ADDR_W'(1);
               default:  ;
            endcase
         end

         if (state == READY && pe_ack && !last_tile)
            tile_idx_q <= tile_idx_q + 16'd1;

         vld_pipe[1] <= acc;
         tag_pipe[1] <= acc ? cur_sel : SEL_NONE;
         for (int i = 2; i <= RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
         end

         buf_wr_en <= vld_pipe[RD_LAT];
         buf_sel   <= vld_pipe[RD_LAT] ? tag_pipe[RD_LAT] : SEL_NONE;
         if (vld_pipe[RD_LAT]) buf_data <= mem_rdata;
      end
   end

   assign tile_ready = (state == READY);
   assign busy       = (state != IDLE);
   assign done       = (state == FIN);
   assign tile_idx   = tile_idx_q;

endmodule
